seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Sequencing controller for the two-digit 7-segment display path. Accepts a 6-bit binary value on a load strobe, converts it to two BCD digits with an iterative shift-and-add-3 engine (one bit per clock), holds the result in a display register, and time-multiplexes the two digits onto one shared segment bus with a one-hot digit enable. Sits between the value producer and the physical display pins.

## Interface
- REFRESH_DIV, 1000: clock cycles each digit stays enabled; legal range 2..65535.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- load  input  1  start conversion of `bin`; honoured only when `busy`=0.
- bin  input  6  binary value 0..63, sampled on the edge that accepts `load`.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: `bcd_q` just updated.
- bcd_q  output  8  displayed value, [7:4] tens, [3:0] ones.
- dig_en  output  2  one-hot digit enable: 2'b10 tens, 2'b01 ones.
- seg  output  7  segments {a,b,c,d,e,f,g}, active-high; bit 6 = a.

## Operation
- FSM states: IDLE, CONV, UPDATE.
- IDLE: `load`=1 at an edge -> capture `bin` into shift register, clear 8-bit scratch BCD, iteration counter = 0, go CONV.
- CONV: each cycle, per nibble of scratch: if nibble >= 5 add 3 (4-bit, no carry out); then shift {scratch, shift_reg} left by 1, MSB of `bin` entering scratch bit 0. After the 6th iteration go UPDATE.
- UPDATE: `bcd_q` <= scratch, `done`=1 for this edge only, go IDLE.
- `load` while `busy`=1 ignored, no queueing; `bin` changes during CONV have no effect.
- `bcd_q` holds its previous value for the whole conversion; display never shows partial results.
- Scanner runs independently of FSM: counter 0..REFRESH_DIV-1; on wrap, `dig_en` toggles 10<->01.
- `seg` combinationally decodes the nibble selected by `dig_en` from `bcd_q`: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; nibble >9 -> 0000000 (unreachable in normal operation).

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, bcd_q=8'h00, scan counter 0, dig_en=2'b10, hence seg=1111110 (0000000 with blanking enabled).
- Reset mid-conversion: conversion abandoned, no done pulse, bcd_q cleared to 0.
- `load` sampled at edge E0 -> busy=1 after E0; iterations at E1..E6; at E7 bcd_q updates, done=1, busy=0. Load-to-done latency 7 cycles.
- done high exactly the cycle after E7; next `load` accepted at E8 at earliest (back-to-back throughput one conversion per 8 cycles).
- `busy` is 1 after E0 through E6 inclusive, i.e. 7 cycles.
- Digit switch: `dig_en` changes on the edge where counter wraps; each digit enabled exactly REFRESH_DIV cycles; full frame 2*REFRESH_DIV.
- bcd_q update mid-slot: `seg` reflects new value immediately after E7; `dig_en` and scan counter unaffected.

## Configuration
- SEG_LEADING_BLANK_EN defined: when tens nibble of `bcd_q` is 0 and `dig_en`=2'b10, `seg`=0000000 (value 7 shows as blank-7). Ones digit always shown.
- Not defined: tens digit shows 0 as 1111110.

## Test plan
- Reset: hold rst_n=0 2 cycles -> busy=0, done=0, bcd_q=8'h00, dig_en=2'b10, seg=1111110 (0000000 with SEG_LEADING_BLANK_EN).
- bin=62, load 1 cycle -> busy 7 cycles, done pulse at E7, bcd_q=8'h62; tens slot seg=1011111, ones slot seg=1101101.
- Sweep bin=0..63 each followed by done -> bcd_q tens*10+ones equals bin every time; bin=63 -> 8'h63, bin=9 -> 8'h09.
- bin=25 loaded, then load with bin=40 at E3 -> ignored, bcd_q=8'h25, single done pulse.
- REFRESH_DIV=4: dig_en toggles every 4 cycles across a bcd_q update; with macro, bin=7 -> tens slot seg=0000000, ones slot 1110000.
- rst_n=0 at E4 of conversion of bin=50 -> no done, bcd_q=8'h00, busy=0; next load of 50 completes normally with 8'h50.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Two-digit 7-segment controller: serial double-dabble BCD conversion plus digit scan.
// Optional define SEG_LEADING_BLANK_EN blanks the tens digit when it is zero.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd_q,
  output logic [1:0] dig_en,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  shreg_q, shreg_d;
  logic [7:0]  scratch_q, scratch_d;
  logic [7:0]  bcd_d;
  logic [2:0]  iter_q, iter_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  dig_q, dig_d;
  logic [7:0]  adj;
  logic [3:0]  nib;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      dig_q     <= 2'b10;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    done_d    = 1'b0;

    // add-3 correction applied before the shift, per nibble, carry discarded
    adj = scratch_q;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;

    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d   = bin;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd5) state_d = UPDATE;
      end
      UPDATE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // free-running scan, independent of the conversion FSM
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    dig_d = dig_q;
    if (cnt_q == 16'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      dig_d = ~dig_q;
    end
  end

  always_comb begin
    nib = dig_q[1] ? bcd_q[7:4] : bcd_q[3:0];
    case (nib)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
`ifdef SEG_LEADING_BLANK_EN
    if (dig_q[1] && (bcd_q[7:4] == 4'd0)) seg = 7'b0000000;
`else
`endif
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign dig_en = dig_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-count/arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n, load;
  logic [5:0] bin;
  logic       busy, done;
  logic [7:0] bcd_q;
  logic [1:0] dig_en;
  logic [6:0] seg;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          k = 0;       // edges since last reset edge
  int          age = -1;    // edges since accepted load, -1 when idle
  int          pend = 0;
  logic [7:0]  m_bcd = 8'h00;
  logic        m_done = 1'b0;

  logic [6:0] seg_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011};

  seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bin(bin),
    .busy(busy), .done(done), .bcd_q(bcd_q), .dig_en(dig_en), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] e_dig;
    logic [3:0] e_nib;
    logic [6:0] e_seg;
    e_dig = (((k / int'(DIV)) % 2) == 0) ? 2'b10 : 2'b01;
    e_nib = e_dig[1] ? m_bcd[7:4] : m_bcd[3:0];
    e_seg = seg_tab[e_nib];
`ifdef SEG_LEADING_BLANK_EN
    if (e_dig[1] && m_bcd[7:4] == 4'd0) e_seg = 7'b0000000;
`endif
    chk("busy",   {7'b0, busy},   {7'b0, age >= 0});
    chk("done",   {7'b0, done},   {7'b0, m_done});
    chk("bcd_q",  bcd_q,          m_bcd);
    chk("dig_en", {6'b0, dig_en}, {6'b0, e_dig});
    chk("seg",    {1'b0, seg},    {1'b0, e_seg});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      k = 0; age = -1; m_bcd = 8'h00; m_done = 1'b0;
    end else begin
      k++;
      m_done = 1'b0;
      if (age >= 0) begin
        age++;
        if (age == 7) begin
          m_bcd = to_bcd(pend); m_done = 1'b1; age = -1;
        end
      end else if (load) begin
        age = 0; pend = int'(bin);
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; bin = '0;
    step(); step();
    chk("reset_bcd", bcd_q, 8'h00);

    // directed: 62
    rst_n = 1'b1;
    load = 1'b1; bin = 6'd62;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bin = 6'($urandom);
      step();
    end
    chk("bcd_62", bcd_q, 8'h62);

    // sweep all values with load spam during conversion
    for (int v = 0; v < 64; v++) begin
      load = 1'b1; bin = 6'(v);
      step();
      for (int i = 0; i < 7; i++) begin
        load = 1'($urandom_range(0, 1)); bin = 6'($urandom);
        step();
      end
      load = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      if (v == 9)  chk("bcd_9", bcd_q, 8'h09);
      if (v == 63) chk("bcd_63", bcd_q, 8'h63);
    end

    // load ignored while busy
    load = 1'b1; bin = 6'd25; step();
    load = 1'b0; step(); step();
    load = 1'b1; bin = 6'd40; step();
    load = 1'b0;
    repeat (6) step();
    chk("bcd_25", bcd_q, 8'h25);

    // value 7 across digit slots
    load = 1'b1; bin = 6'd7; step();
    load = 1'b0;
    repeat (12) step();

    // reset mid-conversion
    load = 1'b1; bin = 6'd50; step();
    load = 1'b0; step(); step(); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    chk("rst_mid_bcd", bcd_q, 8'h00);
    repeat (3) step();
    load = 1'b1; bin = 6'd50; step();
    load = 1'b0;
    repeat (8) step();
    chk("bcd_50", bcd_q, 8'h50);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      load = 1'($urandom_range(0, 3) == 0);
      bin  = 6'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
